// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if : operand/opcode/result bus between sequencer and ALU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface alu_op_sequencer_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  modport master (
    output alu_a, alu_b, alu_opcode,
    input  alu_result, alu_flags
  );

  modport slave (
    input  alu_a, alu_b, alu_opcode,
    output alu_result, alu_flags
  );
endinterface

`default_nettype wire

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer : debounced push-button entry of A, B, opcode; ALU capture
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_op_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      sw_data,
  input  logic                  btn_next_n,
  input  logic                  btn_clear_n,
  alu_op_sequencer_if.master    alu,
  output logic [WIDTH-1:0]      result_q,
  output logic [3:0]            flags_q,
  output logic [2:0]            state_o,
  output logic                  busy,
  output logic                  done
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_LOAD_A  = 3'd0,
    S_LOAD_B  = 3'd1,
    S_LOAD_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_SHOW    = 3'd4
  } state_e;

  logic [1:0] btn_raw_n;
  logic [1:0] press_evt;
  logic       next_evt;
  logic       clear_evt;

  assign btn_raw_n = {btn_clear_n, btn_next_n};
  assign next_evt  = press_evt[0];
  assign clear_evt = press_evt[1];

  // Bit 0 is "next", bit 1 is "clear"; both keys share one debounce structure.
  for (genvar k = 0; k < 2; k++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic            level_q;
    logic            level_d;
    logic            evt_q;
    logic            evt_d;
    logic [DB_W-1:0] cnt_q;
    logic [DB_W-1:0] cnt_d;

    always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
        if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_d = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      evt_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        level_q <= 1'b1;
        cnt_q   <= '0;
        evt_q   <= 1'b0;
      end else begin
        sync1_q <= btn_raw_n[k];
        sync2_q <= sync1_q;
        level_q <= level_d;
        cnt_q   <= cnt_d;
        evt_q   <= evt_d;
      end
    end

    assign press_evt[k] = evt_q;
  end

  logic [3:0] sw_opcode;

  if (WIDTH >= 4) begin : g_op_direct
    assign sw_opcode = sw_data[3:0];
  end else begin : g_op_extend
    assign sw_opcode = {{(4 - WIDTH){1'b0}}, sw_data};
  end

  state_e           state_q,      state_d;
  logic [ST_W-1:0]  settle_q,     settle_d;
  logic [WIDTH-1:0] alu_a_q,      alu_a_d;
  logic [WIDTH-1:0] alu_b_q,      alu_b_d;
  logic [3:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] result_d;
  logic [3:0]       flags_d;
  logic             done_q,       done_d;

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_opcode_d = alu_opcode_q;
    result_d     = result_q;
    flags_d      = flags_q;
    done_d       = 1'b0;

    // Clear outranks everything, including a capture due in this same cycle.
    if (clear_evt) begin
      state_d      = S_LOAD_A;
      settle_d     = '0;
      alu_a_d      = '0;
      alu_b_d      = '0;
      alu_opcode_d = '0;
      result_d     = '0;
      flags_d      = '0;
    end else begin
      case (state_q)
        S_LOAD_A: if (next_evt) begin
          alu_a_d = sw_data;
          state_d = S_LOAD_B;
        end
        S_LOAD_B: if (next_evt) begin
          alu_b_d = sw_data;
          state_d = S_LOAD_OP;
        end
        S_LOAD_OP: if (next_evt) begin
          alu_opcode_d = sw_opcode;
          settle_d     = ST_W'(SETTLE_CYCLES);
          state_d      = S_EXEC;
        end
        S_EXEC: begin
          if (settle_q == ST_W'(1)) begin
            result_d = alu.alu_result;
            flags_d  = alu.alu_flags;
            done_d   = 1'b1;
            state_d  = S_SHOW;
          end else begin
            settle_d = settle_q - 1'b1;
          end
        end
        S_SHOW: if (next_evt) begin
          state_d = S_LOAD_A;
        end
        default: state_d = S_LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD_A;
      settle_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_opcode_q <= alu_opcode_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      done_q       <= done_d;
    end
  end

  assign alu.alu_a      = alu_a_q;
  assign alu.alu_b      = alu_b_q;
  assign alu.alu_opcode = alu_opcode_q;
  assign state_o        = state_q;
  assign busy           = (state_q == S_EXEC);
  assign done           = done_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer : scoreboard bench with behavioural sequencer model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] btn_n;   // [0] next, [1] clear (main); [2] next, [3] clear (long)

  always #5 clk = ~clk;

  // Main instance: short settle
  alu_op_sequencer_if #(.WIDTH(4)) if_m ();
  logic [3:0] result_m, flags_m;
  logic [2:0] state_m;
  logic       busy_m, done_m, c_m;

  alu_op_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sw_data(sw),
    .btn_next_n(btn_n[0]), .btn_clear_n(btn_n[1]),
    .alu(if_m),
    .result_q(result_m), .flags_q(flags_m), .state_o(state_m),
    .busy(busy_m), .done(done_m)
  );

  assign {c_m, if_m.alu_result} = 5'(if_m.alu_a) + 5'(if_m.alu_b);
  assign if_m.alu_flags = {if_m.alu_result[3], if_m.alu_result == 4'd0, c_m,
                           (if_m.alu_a[3] == if_m.alu_b[3]) && (if_m.alu_result[3] != if_m.alu_a[3])};

  // Long instance: settle long enough to press next during EXEC
  alu_op_sequencer_if #(.WIDTH(4)) if_l ();
  logic [3:0] result_l, flags_l;
  logic [2:0] state_l;
  logic       busy_l, done_l, c_l;

  alu_op_sequencer #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(20)) dut_long (
    .clk(clk), .rst_n(rst_n), .sw_data(sw),
    .btn_next_n(btn_n[2]), .btn_clear_n(btn_n[3]),
    .alu(if_l),
    .result_q(result_l), .flags_q(flags_l), .state_o(state_l),
    .busy(busy_l), .done(done_l)
  );

  assign {c_l, if_l.alu_result} = 5'(if_l.alu_a) + 5'(if_l.alu_b);
  assign if_l.alu_flags = {if_l.alu_result[3], if_l.alu_result == 4'd0, c_l,
                           (if_l.alu_a[3] == if_l.alu_b[3]) && (if_l.alu_result[3] != if_l.alu_a[3])};

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference ALU in plain integer arithmetic
  function automatic void ref_alu(input int a, input int b, output int res, output int flags);
    int s, sa, sb, ss;
    s  = a + b;
    res = s % 16;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    ss = sa + sb;
    flags = ((res > 7) ? 8 : 0) + ((res == 0) ? 4 : 0) + ((s > 15) ? 2 : 0) +
            ((ss > 7 || ss < -8) ? 1 : 0);
  endfunction

  typedef struct {
    int res;
    int flags;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   busy_run = 0;

  // Sequencer model: 0=A, 1=B, 2=OP, 4=SHOW (EXEC is transient)
  int m_state, m_a, m_b, m_op, m_res, m_flags;

  task automatic model_clear();
    m_state = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0;
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && done_m) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_result", int'(result_m), mon_e.res);
        chk("done_flags", int'(flags_m), mon_e.flags);
        chk("busy_cycles", busy_run, 2);
      end
    end
    if (busy_m) busy_run++;
    else busy_run = 0;
  end

  task automatic press(input logic [3:0] mask, input int low, input int tail);
    @(posedge clk); #2;
    btn_n = btn_n & ~mask;
    repeat (low) @(posedge clk);
    #2 btn_n = btn_n | mask;
    repeat (tail) @(posedge clk);
  endtask

  task automatic check_all(input string tag);
    @(posedge clk); #1;
    chk({tag, "_state"},  int'(state_m), m_state);
    chk({tag, "_a"},      int'(if_m.alu_a), m_a);
    chk({tag, "_b"},      int'(if_m.alu_b), m_b);
    chk({tag, "_op"},     int'(if_m.alu_opcode), m_op);
    chk({tag, "_result"}, int'(result_m), m_res);
    chk({tag, "_flags"},  int'(flags_m), m_flags);
    chk({tag, "_busy"},   int'(busy_m), 0);
  endtask

  task automatic do_next(input int sw_val, input int low);
    sw = 4'(sw_val);
    case (m_state)
      0: begin m_a = sw_val; m_state = 1; end
      1: begin m_b = sw_val; m_state = 2; end
      2: begin
        m_op = sw_val;
        ref_alu(m_a, m_b, m_res, m_flags);
        exp_q.push_back('{m_res, m_flags});
        m_state = 4;
      end
      default: m_state = 0;
    endcase
    press(4'b0001, low, 12);
    sw = 4'($urandom_range(0, 15));
  endtask

  task automatic do_clear();
    model_clear();
    press(4'b0010, 10, 12);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    btn_n = 4'hF;
    sw    = 4'h0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(state_m), 0);
    chk("rst_a", int'(if_m.alu_a), 0);
    chk("rst_result", int'(result_m), 0);
    chk("rst_busy_done", int'({busy_m, done_m}), 0);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Basic A=3, B=5, op=0
    do_next(3, 10); check_all("t1_a");
    do_next(5, 10); check_all("t1_b");
    do_next(0, 10); check_all("t1_exec");
    chk("t1_result_const", int'(result_m), 8);
    chk("t1_flags_const", int'(flags_m), 4'b1001);

    // Zero and carry
    do_next(1, 10); check_all("t2_show_next");
    do_next(9, 10);
    do_next(7, 10);
    do_next($urandom_range(0, 15), 10); check_all("t2_exec");
    chk("t2_flags_const", int'(flags_m), 4'b0110);
    do_next(2, 10); check_all("t2_back");

    // Bounce shorter than the debounce window
    sw = 4'hC;
    repeat (5) begin
      @(posedge clk); #2 btn_n[0] = 1'b0;
      repeat (3) @(posedge clk);
      #2 btn_n[0] = 1'b1;
    end
    repeat (12) @(posedge clk);
    check_all("t3_bounce");
    do_next(6, 10); check_all("t3_clean");
    do_next(4, 10);
    do_next(1, 10);
    do_next(0, 10); check_all("t3_done");

    // Long hold gives a single event
    do_next(11, 200); check_all("t4_hold");
    do_next(13, 10);
    do_next(5, 10);
    do_next(0, 10); check_all("t4_done");

    // Randomised operations
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) do_next($urandom_range(0, 15), 10);
      check_all("rand");
    end

    // Clear in LOAD_OP
    do_next(3, 10);
    do_next(5, 10); check_all("t6_pre_clear");
    do_clear(); check_all("t6_clear");

    // Clear and next together: clear wins
    do_next(7, 10);
    sw = 4'hA;
    model_clear();
    press(4'b0011, 10, 12);
    check_all("t6_both");

    // Reset in the middle of EXEC
    do_next(3, 10);
    do_next(5, 10);
    sw = 4'h0;
    @(posedge clk); #2 btn_n[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (busy_m) seen = 1;
    end
    chk("t6_exec_reached", seen, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_state", int'(state_m), 0);
    chk("t6_async_a", int'(if_m.alu_a), 0);
    chk("t6_async_b", int'(if_m.alu_b), 0);
    chk("t6_async_busy", int'(busy_m), 0);
    btn_n[0] = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b1;
    model_clear();
    repeat (20) @(posedge clk);
    check_all("t6_after_rst");

    // Next pressed during a long EXEC is dropped
    sw = 4'd2; press(4'b0100, 10, 12);
    sw = 4'd6; press(4'b0100, 10, 12);
    sw = 4'd1; press(4'b0100, 10, 0);
    @(posedge clk); #1;
    chk("t5_in_exec", int'(busy_l), 1);
    press(4'b0100, 10, 12);
    repeat (30) @(posedge clk);
    #1;
    chk("t5_state", int'(state_l), 4);
    chk("t5_result", int'(result_l), 8);
    chk("t5_flags", int'(flags_l), 4'b1001);

    chk("pending_done", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
